// File: rtl/draw_dispatcher_pkg.sv
// Shared definitions for the draw dispatcher: opcodes, FSM states, coordinate widths.
package draw_dispatcher_pkg;

    localparam int INSTR_W = 36;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;

    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_RD   = 3'b101;
    localparam logic [2:0] OP_CD   = 3'b110;
    localparam logic [2:0] OP_DISP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Opcode lives in the top three bits; the rest are engine operands.
    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 3];
    endfunction

endpackage

// File: rtl/draw_dispatcher_cmd_fifo.sv
// Command FIFO: power-of-two depth, registered pointers, no full-time lookahead.
module cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/draw_dispatcher.sv
// Draw dispatcher: queues host draw commands and issues them one at a time to
// the line or circle engine, with timeout abort and a merged pixel stream.
module draw_dispatcher
    import draw_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [INSTR_W-1:0]    cmd_in,
    output logic                  ln_start,
    output logic                  cd_start,
    output logic [INSTR_W-1:0]    eng_instr,
    input  logic                  ln_done,
    input  logic                  cd_done,
    input  logic                  ln_pix_valid,
    input  logic signed [X_W-1:0] ln_x,
    input  logic signed [Y_W-1:0] ln_y,
    input  logic                  cd_pix_valid,
    input  logic signed [X_W-1:0] cd_x,
    input  logic signed [Y_W-1:0] cd_y,
    output logic                  pix_valid,
    output logic signed [X_W-1:0] x_out,
    output logic signed [Y_W-1:0] y_out,
    output logic                  eng_abort,
    output logic                  disp_pulse,
    output logic                  cmd_err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    // Abort is registered on the edge that moves the counter to TIMEOUT-1,
    // so the pulse is visible in the cycle the counter holds TIMEOUT-1.
    localparam logic [TW-1:0] TMO_ABORT = TW'(TIMEOUT - 2);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [INSTR_W-1:0]    w_head;
    logic [2:0]            w_head_op;
    logic [2:0]            w_op;
    logic                  w_done;
    logic                  w_sel_valid;
    logic signed [X_W-1:0] w_sel_x;
    logic signed [Y_W-1:0] w_sel_y;
    logic                  w_accept;

    state_t                r_state;
    logic [INSTR_W-1:0]    r_instr;
    logic                  r_active_cd;
    logic [TW-1:0]         r_tmo;
    logic                  r_ln_start;
    logic                  r_cd_start;
    logic                  r_disp;
    logic                  r_err;
    logic                  r_abort;
    logic                  r_pix_valid;
    logic signed [X_W-1:0] r_x;
    logic signed [Y_W-1:0] r_y;

    cmd_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cmd_ready   = !w_full;
    assign w_push      = cmd_valid && !w_full;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_head_op   = opcode_of(w_head);
    assign w_op        = opcode_of(r_instr);
    assign w_done      = r_active_cd ? cd_done : ln_done;
    assign w_sel_valid = r_active_cd ? cd_pix_valid : ln_pix_valid;
    assign w_sel_x     = r_active_cd ? cd_x : ln_x;
    assign w_sel_y     = r_active_cd ? cd_y : ln_y;
    assign w_accept    = (r_state == ST_WAIT) && w_sel_valid;

    // Dispatch FSM; start pulses are registered on the pop so they show in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_active_cd <= 1'b0;
            r_tmo       <= '0;
            r_ln_start  <= 1'b0;
            r_cd_start  <= 1'b0;
            r_disp      <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_ln_start <= 1'b0;
            r_cd_start <= 1'b0;
            r_disp     <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_instr     <= w_head;
                        r_active_cd <= (w_head_op == OP_CD);
                        r_ln_start  <= (w_head_op == OP_LD);
                        r_cd_start  <= (w_head_op == OP_CD);
                        r_disp      <= (w_head_op == OP_DISP);
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo <= '0;
                    case (w_op)
                        OP_LD, OP_CD: r_state <= ST_WAIT;
                        OP_DISP:      r_state <= ST_IDLE;
                        default: begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    endcase
                end
                ST_WAIT: begin
                    // A done arriving at the threshold takes priority over abort.
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_tmo == TMO_ABORT) begin
                            r_abort <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel mux: register only the active engine's pixels while waiting on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            r_pix_valid <= w_accept;
            if (w_accept) begin
                r_x <= w_sel_x;
                r_y <= w_sel_y;
            end
        end
    end

    assign ln_start   = r_ln_start;
    assign cd_start   = r_cd_start;
    assign disp_pulse = r_disp;
    assign cmd_err    = r_err;
    assign eng_abort  = r_abort;
    assign eng_instr  = r_instr;
    assign pix_valid  = r_pix_valid;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_draw_dispatcher.sv
// Directed testbench for draw_dispatcher (FIFO_DEPTH=4, TIMEOUT=16).
module tb_draw_dispatcher;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [35:0]        cmd_in = '0;
    logic               ln_start, cd_start;
    logic [35:0]        eng_instr;
    logic               ln_done = 1'b0, cd_done = 1'b0;
    logic               ln_pix_valid = 1'b0, cd_pix_valid = 1'b0;
    logic signed [8:0]  ln_x = '0, cd_x = '0;
    logic signed [7:0]  ln_y = '0, cd_y = '0;
    logic               pix_valid;
    logic signed [8:0]  x_out;
    logic signed [7:0]  y_out;
    logic               eng_abort, disp_pulse, cmd_err, busy;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int n_ln = 0, n_cd = 0, n_disp = 0, n_err = 0, n_abort = 0;
    int t_ln = 0, t_cd = 0, t_disp = 0, t_err = 0, t_abort = 0;
    logic [35:0] issued[$];

    draw_dispatcher #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_in       (cmd_in),
        .ln_start     (ln_start),
        .cd_start     (cd_start),
        .eng_instr    (eng_instr),
        .ln_done      (ln_done),
        .cd_done      (cd_done),
        .ln_pix_valid (ln_pix_valid),
        .ln_x         (ln_x),
        .ln_y         (ln_y),
        .cd_pix_valid (cd_pix_valid),
        .cd_x         (cd_x),
        .cd_y         (cd_y),
        .pix_valid    (pix_valid),
        .x_out        (x_out),
        .y_out        (y_out),
        .eng_abort    (eng_abort),
        .disp_pulse   (disp_pulse),
        .cmd_err      (cmd_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts and timestamps every output pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ln_start)   begin n_ln    <= n_ln + 1;    t_ln    <= cyc; issued.push_back(eng_instr); end
        if (cd_start)   begin n_cd    <= n_cd + 1;    t_cd    <= cyc; issued.push_back(eng_instr); end
        if (disp_pulse) begin n_disp  <= n_disp + 1;  t_disp  <= cyc; end
        if (cmd_err)    begin n_err   <= n_err + 1;   t_err   <= cyc; end
        if (eng_abort)  begin n_abort <= n_abort + 1; t_abort <= cyc; end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [35:0] c);
        int w;
        cmd_valid = 1'b1;
        cmd_in    = c;
        w = 0;
        while (!cmd_ready && w < 60) begin tick; w++; end
        if (w >= 60) begin
            n_chk++; n_fail++;
            $display("FAIL push_wait: cmd_ready stayed %0b, required 1", cmd_ready);
        end
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int w;
        w = 0;
        while (busy && w < 80) begin tick; w++; end
        if (w >= 80) begin
            n_chk++; n_fail++;
            $display("FAIL idle_wait: busy stayed %0b, required 0", busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick; tick;
        n_chk++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy_pix: busy=%0b pix_valid=%0b, required 0 0", busy, pix_valid); end
        n_chk++; if ({ln_start, cd_start, disp_pulse, cmd_err, eng_abort} !== 5'b0) begin n_fail++;
            $display("FAIL rst_pulses: got %b, required 00000", {ln_start, cd_start, disp_pulse, cmd_err, eng_abort}); end
        reset = 1'b0;
        tick;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_ready: got %0b, required 1", cmd_ready); end
        n_chk++; if (eng_instr !== 36'h0 || x_out !== 9'sd0 || y_out !== 8'sd0) begin n_fail++;
            $display("FAIL rst_data: eng_instr=%h x=%0d y=%0d, required 0 0 0", eng_instr, x_out, y_out); end
    endtask

    task automatic test_ld_basic;
        int bl, bc, w;
        bl = n_ln; bc = n_cd;
        push_cmd(36'h800000000);
        w = 0;
        while ((n_ln - bl) < 1 && w < 20) begin tick; w++; end
        n_chk++; if (eng_instr !== 36'h800000000) begin n_fail++;
            $display("FAIL ld_instr: got %h, required 800000000", eng_instr); end
        repeat (9) tick;
        n_chk++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL ld_busy_wait: got %0b, required 1", busy); end
        ln_done = 1'b1;
        tick;
        ln_done = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL ld_busy_after_done: got %0b, required 0", busy); end
        repeat (3) tick;
        n_chk++; if ((n_ln - bl) !== 1 || (n_cd - bc) !== 0) begin n_fail++;
            $display("FAIL ld_starts: ln=%0d cd=%0d, required 1 0", n_ln - bl, n_cd - bc); end
        n_chk++; if (eng_instr !== 36'h800000000) begin n_fail++;
            $display("FAIL ld_instr_hold: got %h, required 800000000", eng_instr); end
    endtask

    task automatic test_fifo_full_order;
        logic [35:0] cmds [5];
        int bc, qb, w;
        bc = n_cd; qb = issued.size();
        for (int k = 0; k < 5; k++) cmds[k] = {3'b110, 33'(k + 1)};
        for (int k = 0; k < 5; k++) push_cmd(cmds[k]);
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++;
            $display("FAIL fifo_full_ready: got %0b, required 0", cmd_ready); end
        n_chk++; if ((n_cd - bc) !== 1) begin n_fail++;
            $display("FAIL fifo_one_issued: got %0d, required 1", n_cd - bc); end
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while ((n_cd - bc) < k + 1 && w < 20) begin tick; w++; end
            tick; tick;
            cd_done = 1'b1;
            tick;
            cd_done = 1'b0;
            if (k == 0) begin
                tick;
                n_chk++; if (cmd_ready !== 1'b1) begin n_fail++;
                    $display("FAIL fifo_ready_after_pop: got %0b, required 1", cmd_ready); end
            end
        end
        wait_idle;
        n_chk++; if ((issued.size() - qb) !== 5) begin n_fail++;
            $display("FAIL fifo_issue_count: got %0d, required 5", issued.size() - qb); end
        for (int k = 0; k < 5; k++) begin
            if (qb + k < issued.size()) begin
                n_chk++; if (issued[qb + k] !== cmds[k]) begin n_fail++;
                    $display("FAIL fifo_order_%0d: got %h, required %h", k, issued[qb + k], cmds[k]); end
            end
        end
    endtask

    task automatic test_illegal_then_disp;
        int bl, bc, be, bd, ba;
        bl = n_ln; bc = n_cd; be = n_err; bd = n_disp; ba = n_abort;
        push_cmd(36'h612345678);
        push_cmd(36'hE00000042);
        wait_idle;
        tick;
        n_chk++; if ((n_err - be) !== 1 || (n_disp - bd) !== 1) begin n_fail++;
            $display("FAIL illegal_counts: err=%0d disp=%0d, required 1 1", n_err - be, n_disp - bd); end
        n_chk++; if ((n_ln - bl) !== 0 || (n_cd - bc) !== 0 || (n_abort - ba) !== 0) begin n_fail++;
            $display("FAIL illegal_no_engine: ln=%0d cd=%0d abort=%0d, required 0 0 0", n_ln - bl, n_cd - bc, n_abort - ba); end
        n_chk++; if (!(t_err < t_disp)) begin n_fail++;
            $display("FAIL illegal_order: err at %0d disp at %0d, required err first", t_err, t_disp); end
        n_chk++; if (eng_instr !== 36'hE00000042) begin n_fail++;
            $display("FAIL disp_instr: got %h, required e00000042", eng_instr); end
    endtask

    task automatic test_timeout;
        int bc, be, ba, w;
        bc = n_cd; be = n_err; ba = n_abort;
        push_cmd(36'h8000000AA);
        push_cmd(36'hC000000BB);
        w = 0;
        while ((n_cd - bc) < 1 && w < 60) begin tick; w++; end
        n_chk++; if ((n_abort - ba) !== 1 || (n_err - be) !== 1) begin n_fail++;
            $display("FAIL tmo_counts: abort=%0d err=%0d, required 1 1", n_abort - ba, n_err - be); end
        n_chk++; if ((t_abort - t_ln) !== 16 || t_err !== t_abort) begin n_fail++;
            $display("FAIL tmo_timing: abort-start=%0d err-abort=%0d, required 16 0", t_abort - t_ln, t_err - t_abort); end
        n_chk++; if ((t_cd - t_abort) !== 2 || eng_instr !== 36'hC000000BB) begin n_fail++;
            $display("FAIL tmo_next: gap=%0d instr=%h, required 2 c000000bb", t_cd - t_abort, eng_instr); end
        tick;
        cd_done = 1'b1;
        tick;
        cd_done = 1'b0;
        wait_idle;
    endtask

    task automatic test_done_wins;
        int bl, be, ba, w;
        bl = n_ln; be = n_err; ba = n_abort;
        push_cmd(36'h800000077);
        w = 0;
        while ((n_ln - bl) < 1 && w < 20) begin tick; w++; end
        repeat (14) tick;
        ln_done = 1'b1;
        tick;
        ln_done = 1'b0;
        repeat (2) tick;
        n_chk++; if ((n_abort - ba) !== 0 || (n_err - be) !== 0) begin n_fail++;
            $display("FAIL done_wins: abort=%0d err=%0d, required 0 0", n_abort - ba, n_err - be); end
        n_chk++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL done_wins_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_pixel_mux;
        int bc, w;
        bc = n_cd;
        push_cmd(36'hC00000005);
        w = 0;
        while ((n_cd - bc) < 1 && w < 20) begin tick; w++; end
        for (int i = 0; i < 4; i++) begin
            ln_pix_valid = (i % 2 == 0);
            ln_x = -9'sd5;
            ln_y = 8'sd3;
            tick;
            n_chk++; if (pix_valid !== 1'b0) begin n_fail++;
                $display("FAIL pix_inactive_%0d: pix_valid=%0b, required 0", i, pix_valid); end
        end
        ln_pix_valid = 1'b0;
        cd_pix_valid = 1'b1; cd_x = 9'sd100; cd_y = -8'sd20;
        tick;
        cd_pix_valid = 1'b0;
        n_chk++; if (pix_valid !== 1'b1 || x_out !== 9'sd100 || y_out !== -8'sd20) begin n_fail++;
            $display("FAIL pix_active: v=%0b x=%0d y=%0d, required 1 100 -20", pix_valid, x_out, y_out); end
        tick;
        n_chk++; if (pix_valid !== 1'b0 || x_out !== 9'sd100) begin n_fail++;
            $display("FAIL pix_gap: v=%0b x=%0d, required 0 100", pix_valid, x_out); end
        cd_pix_valid = 1'b1; cd_x = -9'sd7; cd_y = 8'sd9; cd_done = 1'b1;
        tick;
        cd_pix_valid = 1'b0; cd_done = 1'b0;
        n_chk++; if (pix_valid !== 1'b1 || x_out !== -9'sd7 || y_out !== 8'sd9) begin n_fail++;
            $display("FAIL pix_last: v=%0b x=%0d y=%0d, required 1 -7 9", pix_valid, x_out, y_out); end
        tick;
        cd_pix_valid = 1'b1; cd_x = 9'sd55; cd_y = 8'sd1;
        tick;
        cd_pix_valid = 1'b0;
        n_chk++; if (pix_valid !== 1'b0 || x_out !== -9'sd7) begin n_fail++;
            $display("FAIL pix_idle: v=%0b x=%0d, required 0 -7", pix_valid, x_out); end
    endtask

    task automatic test_reset_mid_op;
        int bl, bc, ba, w;
        bl = n_ln; ba = n_abort;
        push_cmd(36'h800000011);
        w = 0;
        while ((n_ln - bl) < 1 && w < 20) begin tick; w++; end
        push_cmd(36'hC00000021);
        push_cmd(36'hC00000022);
        push_cmd(36'hC00000023);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_chk++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL midrst_state: busy=%0b ready=%0b, required 0 1", busy, cmd_ready); end
        n_chk++; if (eng_instr !== 36'h0) begin n_fail++;
            $display("FAIL midrst_instr: got %h, required 0", eng_instr); end
        bl = n_ln; bc = n_cd;
        repeat (6) tick;
        n_chk++; if ((n_ln - bl) !== 0 || (n_cd - bc) !== 0 || (n_abort - ba) !== 0) begin n_fail++;
            $display("FAIL midrst_quiet: ln=%0d cd=%0d abort=%0d, required 0 0 0", n_ln - bl, n_cd - bc, n_abort - ba); end
    endtask

    initial begin
        test_reset;
        test_ld_basic;
        test_fifo_full_order;
        test_illegal_then_disp;
        test_timeout;
        test_done_wins;
        test_pixel_mux;
        test_reset_mid_op;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
